// File: rtl/glitc_config_ctrl.sv
// Configuration sequencer for the four GLITC FPGAs: drives PROGRAM_B/INIT_B,
// watches INIT_B/DONE, and exposes start/abort control plus status/error readback.
//
// state      | meaning
// UNCONF     | idle, pins released, waiting for start
// PROG       | PROGRAM_B and INIT_B held low
// INIT_HOLD  | PROGRAM_B released, INIT_B still held low
// INIT_WAIT  | INIT_B released, waiting for the FPGA to raise it
// LOADING    | bitstream bytes pushed over GLITCBUS, waiting for DONE
// READY      | configured, gready asserted
// ERROR      | timeout / CRC / DONE-lost; parked until start or abort
module glitc_config_ctrl #(
  parameter int PROG_CYCLES      = 64,
  parameter int INIT_HOLD_CYCLES = 64,
  parameter int INIT_TIMEOUT     = 65536
) (
  input  logic        clk_i,
  input  logic        rst_b_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [3:0]  PROGRAM_B,
  output logic [3:0]  init_b_oe,
  input  logic [3:0]  INIT_B,
  input  logic [3:0]  DONE,
  output logic [3:0]  gready_o
);

  typedef enum logic [2:0] {
    ST_UNCONF    = 3'd0,
    ST_PROG      = 3'd1,
    ST_INIT_HOLD = 3'd2,
    ST_INIT_WAIT = 3'd3,
    ST_LOADING   = 3'd4,
    ST_READY     = 3'd5,
    ST_ERROR     = 3'd6
  } state_e;

  localparam logic [16:0] PROG_LAST = 17'(PROG_CYCLES - 1);
  localparam logic [16:0] HOLD_LAST = 17'(INIT_HOLD_CYCLES - 1);
  localparam logic [16:0] TO_LAST   = 17'(INIT_TIMEOUT - 1);

  logic [3:0]  init_m_q, init_s_q, done_m_q, done_s_q;
  state_e      state_q [4];
  state_e      state_d [4];
  logic [16:0] cnt_q [4];
  logic [16:0] cnt_d [4];
  logic [3:0]  err_to_q, err_to_d, err_crc_q, err_crc_d, err_lost_q, err_lost_d;
  logic [3:0]  prog_b_q, prog_b_d, init_oe_q, init_oe_d, gready_q, gready_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        accept, wr_ctrl;
  logic [3:0]  start, abort;
  logic [31:0] status;
  logic        unused_dat;

  assign unused_dat = ^dat_i[31:8];

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      init_m_q <= '0;
      init_s_q <= '0;
      done_m_q <= '0;
      done_s_q <= '0;
    end else begin
      init_m_q <= INIT_B;
      init_s_q <= init_m_q;
      done_m_q <= DONE;
      done_s_q <= done_m_q;
    end
  end

  always_comb begin
    accept  = cyc_i & stb_i & ~ack_q;
    wr_ctrl = accept & we_i & (adr_i == 2'd0);
    start   = wr_ctrl ? dat_i[3:0] : 4'h0;
    abort   = wr_ctrl ? dat_i[7:4] : 4'h0;
    status  = '0;
    for (int n = 0; n < 4; n++) status[4*n +: 3] = state_q[n];
    status[19:16] = gready_q;
    status[23:20] = done_s_q;
    status[27:24] = init_s_q;
    ack_d = accept;
    dat_d = '0;
    if (accept && !we_i) begin
      case (adr_i)
        2'd1:    dat_d = status;
        2'd2:    dat_d = {20'h0, err_lost_q, err_crc_q, err_to_q};
        default: dat_d = '0;
      endcase
    end
  end

  always_comb begin
    err_to_d   = err_to_q;
    err_crc_d  = err_crc_q;
    err_lost_d = err_lost_q;
    prog_b_d   = 4'hF;
    init_oe_d  = 4'h0;
    gready_d   = 4'h0;
    for (int n = 0; n < 4; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n] + 17'd1;
      case (state_q[n])
        ST_PROG:      if (cnt_q[n] == PROG_LAST) state_d[n] = ST_INIT_HOLD;
        ST_INIT_HOLD: if (cnt_q[n] == HOLD_LAST) state_d[n] = ST_INIT_WAIT;
        ST_INIT_WAIT: begin
          if (init_s_q[n]) begin
            state_d[n] = ST_LOADING;
          end else if (cnt_q[n] == TO_LAST) begin
            state_d[n]  = ST_ERROR;
            err_to_d[n] = 1'b1;
          end
        end
        ST_LOADING: begin
          // DONE takes priority over a simultaneous INIT_B drop
          if (done_s_q[n]) begin
            state_d[n] = ST_READY;
          end else if (!init_s_q[n]) begin
            state_d[n]   = ST_ERROR;
            err_crc_d[n] = 1'b1;
          end
        end
        ST_READY: begin
          if (!done_s_q[n]) begin
            state_d[n]    = ST_ERROR;
            err_lost_d[n] = 1'b1;
          end
        end
        default: ;
      endcase
      if (abort[n] || start[n]) begin
        state_d[n]    = abort[n] ? ST_UNCONF : ST_PROG;
        err_to_d[n]   = 1'b0;
        err_crc_d[n]  = 1'b0;
        err_lost_d[n] = 1'b0;
      end
      if ((state_d[n] != state_q[n]) || start[n] || abort[n]) cnt_d[n] = '0;
      prog_b_d[n]  = (state_d[n] != ST_PROG);
      init_oe_d[n] = (state_d[n] == ST_PROG) || (state_d[n] == ST_INIT_HOLD);
      gready_d[n]  = (state_d[n] == ST_READY);
    end
  end

  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= ST_UNCONF;
        cnt_q[n]   <= '0;
      end
      err_to_q   <= '0;
      err_crc_q  <= '0;
      err_lost_q <= '0;
      prog_b_q   <= 4'hF;
      init_oe_q  <= '0;
      gready_q   <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= state_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
      err_to_q   <= err_to_d;
      err_crc_q  <= err_crc_d;
      err_lost_q <= err_lost_d;
      prog_b_q   <= prog_b_d;
      init_oe_q  <= init_oe_d;
      gready_q   <= gready_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  assign PROGRAM_B = prog_b_q;
  assign init_b_oe = init_oe_q;
  assign gready_o  = gready_q;
  assign ack_o     = ack_q;
  assign dat_o     = dat_q;

endmodule

// File: tb/tb_glitc_config_ctrl.sv
// Bench for glitc_config_ctrl: directed sequences with randomized delays/bus
// traffic, checked against a timeline model of each channel.
module tb_glitc_config_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_b_i;
  logic        cyc_i, stb_i, we_i;
  logic [1:0]  adr_i;
  logic [31:0] dat_i, dat_o;
  logic        ack_o;
  logic [3:0]  program_b, init_b_oe, init_b_pin, done_pin, gready_o, ext;

  // external pull-up model: pin is low while driven, else whatever the FPGA does
  assign init_b_pin = ext & ~init_b_oe;

  always #5 clk_i = ~clk_i;

  glitc_config_ctrl dut (
    .clk_i(clk_i), .rst_b_i(rst_b_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .PROGRAM_B(program_b), .init_b_oe(init_b_oe), .INIT_B(init_b_pin),
    .DONE(done_pin), .gready_o(gready_o)
  );

  int edges = 0;
  always @(posedge clk_i) edges <= edges + 1;

  int checks = 0;
  int failures = 0;

  // channel model: timed channels follow the start timeline, others use mstate
  int         es [4];
  bit         timed [4];
  int         mstate [4];
  logic [3:0] m_to, m_crc, m_lost;
  int         last_acc;

  function automatic int st_of(int n, int now);
    int t;
    if (!timed[n]) return mstate[n];
    t = now - es[n];
    if (t < 64) return 1;
    if (t < 128) return 2;
    if (t < 128 + 65536) return 3;
    return 6;
  endfunction

  function automatic logic [31:0] exp_status(int now);
    logic [31:0] w;
    int st;
    w = '0;
    for (int n = 0; n < 4; n++) begin
      st = st_of(n, now);
      w[4*n +: 3] = 3'(st);
      w[16+n] = (st == 5);
      w[20+n] = done_pin[n];
      w[24+n] = (st == 1 || st == 2) ? 1'b0 : ext[n];
    end
    return w;
  endfunction

  function automatic logic [31:0] exp_err();
    return {20'h0, m_lost, m_crc, m_to};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
    @(negedge clk_i);
    chk("ack_wr", {31'h0, ack_o}, 32'h1);
    last_acc = edges;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk_i);
    chk("ack_wr_drop", {31'h0, ack_o}, 32'h0);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output int t0);
    t0 = edges;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = a; dat_i = $urandom;
    @(negedge clk_i);
    chk("ack_rd", {31'h0, ack_o}, 32'h1);
    d = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i);
    chk("ack_rd_drop", {31'h0, ack_o}, 32'h0);
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    int t0;
    bus_read(2'd1, d, t0);
    chk(tag, d, exp_status(t0));
  endtask

  task automatic chk_err(input string tag);
    logic [31:0] d;
    int t0;
    bus_read(2'd2, d, t0);
    chk(tag, d, exp_err());
  endtask

  task automatic wait_t(input int n, input int target);
    int k = 0;
    while ((edges - es[n] < target) && k < 100000) begin
      @(negedge clk_i);
      k++;
    end
    if (k >= 100000) chk("wait_t_timeout", 32'(k), 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    int t0, k, dly;
    rst_b_i = 1'b0; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = 0; dat_i = 0;
    ext = 4'h0; done_pin = 4'h0;
    m_to = 0; m_crc = 0; m_lost = 0;
    for (int n = 0; n < 4; n++) begin es[n] = 0; timed[n] = 0; mstate[n] = 0; end
    repeat (3) @(negedge clk_i);
    chk("rst_program_b", {28'h0, program_b}, 32'hF);
    chk("rst_init_oe", {28'h0, init_b_oe}, 32'h0);
    chk("rst_gready", {28'h0, gready_o}, 32'h0);
    chk("rst_ack_dat", {31'h0, ack_o} | dat_o, 32'h0);
    rst_b_i = 1'b1;
    @(negedge clk_i);
    bus_read(2'd1, d, t0);
    chk("status_after_reset", d, 32'h0);
    chk_err("err_after_reset");

    // channel 0 full sequence, channel 2 started alongside to time out later
    bus_write(2'd0, 32'h5);
    es[0] = last_acc; es[2] = last_acc; timed[0] = 1; timed[2] = 1;
    chk("prog_low_ch0_ch2", {28'h0, program_b}, 32'hA);
    k = 0;
    while (program_b[0] !== 1'b1 && k < 200) begin @(negedge clk_i); k++; end
    chk("prog_low_cycles", 32'(edges - es[0]), 32'd64);
    chk("hold_oe", {28'h0, init_b_oe}, 32'h5);
    k = 0;
    while (init_b_oe[0] !== 1'b0 && k < 200) begin @(negedge clk_i); k++; end
    chk("init_hold_end", 32'(edges - es[0]), 32'd128);
    @(negedge clk_i);
    chk_status("ch0_init_wait");
    ext[0] = 1'b1;
    repeat (4) @(negedge clk_i);
    timed[0] = 0; mstate[0] = 4;
    chk_status("ch0_loading");
    dly = $urandom_range(20, 120);
    repeat (dly) @(negedge clk_i);
    done_pin[0] = 1'b1;
    k = 0;
    do begin @(negedge clk_i); k++; end while (gready_o[0] !== 1'b1 && k < 20);
    chk("done_to_gready", 32'(k), 32'd3);
    mstate[0] = 5;
    chk("gready_ch0", {28'h0, gready_o}, 32'h1);
    chk_status("ch0_ready");

    // channel 1: CRC error in LOADING, then restart clears it
    ext[1] = 1'b1;
    repeat (3) @(negedge clk_i);
    bus_write(2'd0, 32'h2);
    es[1] = last_acc; timed[1] = 1;
    wait_t(1, 10);
    chk_status("ch1_prog");
    wait_t(1, 70);
    chk("ch1_hold_pins", {30'h0, program_b[1], init_b_oe[1]}, 32'h3);
    chk_status("ch1_init_hold");
    wait_t(1, 140);
    timed[1] = 0; mstate[1] = 4;
    chk_status("ch1_loading");
    ext[1] = 1'b0;
    repeat (5) @(negedge clk_i);
    mstate[1] = 6; m_crc[1] = 1'b1;
    chk_status("ch1_crc_state");
    chk_err("ch1_crc_err");
    bus_write(2'd0, 32'h2);
    es[1] = last_acc; timed[1] = 1; m_crc[1] = 1'b0;
    wait_t(1, 5);
    chk_err("ch1_crc_cleared");
    chk_status("ch1_restart");
    bus_write(2'd0, 32'h20);
    timed[1] = 0; mstate[1] = 0;
    chk("ch1_abort_pins", {30'h0, program_b[1], init_b_oe[1]}, 32'h2);
    chk_status("ch1_aborted");

    // channel 3: DONE and INIT_B-low together -> READY, then DONE lost
    ext[3] = 1'b1;
    bus_write(2'd0, 32'h8);
    es[3] = last_acc; timed[3] = 1;
    wait_t(3, 140);
    timed[3] = 0; mstate[3] = 4;
    chk_status("ch3_loading");
    done_pin[3] = 1'b1; ext[3] = 1'b0;
    repeat (4) @(negedge clk_i);
    mstate[3] = 5;
    chk("gready_ch0_ch3", {28'h0, gready_o}, 32'h9);
    chk_status("ch3_done_wins");
    chk_err("ch3_no_crc");
    done_pin[3] = 1'b0;
    k = 0;
    do begin @(negedge clk_i); k++; end while (gready_o[3] !== 1'b0 && k < 20);
    chk("done_lost_latency", 32'(k), 32'd3);
    mstate[3] = 6; m_lost[3] = 1'b1;
    chk_err("ch3_done_lost");
    chk_status("ch3_error_state");
    bus_write(2'd0, 32'h88);
    mstate[3] = 0; m_lost[3] = 1'b0;
    chk_status("ch3_abort_wins");
    chk_err("ch3_err_cleared");

    // idle strobe must not be acknowledged
    cyc_i = 1'b1; stb_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("no_ack_without_stb", {31'h0, ack_o}, 32'h0);
    cyc_i = 1'b0;
    @(negedge clk_i);

    // random bus traffic: harmless writes and reads of every address
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) bus_write(2'd3, $urandom);
        else bus_write(2'd0, $urandom & 32'hFFFF_FF00);
      end
      adr_i = 2'($urandom_range(0, 3));
      bus_read(adr_i, d, t0);
      case (adr_i)
        2'd1:    chk("rand_status", d, exp_status(t0));
        2'd2:    chk("rand_err", d, exp_err());
        default: chk("rand_zero_reg", d, 32'h0);
      endcase
    end

    // channel 2 INIT_B timeout boundary
    wait_t(2, 128 + 65536 - 2);
    chk_status("ch2_last_wait");
    chk_status("ch2_timed_out");
    timed[2] = 0; mstate[2] = 6; m_to[2] = 1'b1;
    bus_read(2'd2, d, t0);
    chk("ch2_err_reg", d, 32'h4);
    chk("ch2_gready", {31'h0, gready_o[2]}, 32'h0);

    // async reset in the middle of PROG
    bus_write(2'd0, 32'h1);
    repeat (10) @(negedge clk_i);
    rst_b_i = 1'b0;
    #1;
    chk("async_rst_program_b", {28'h0, program_b}, 32'hF);
    chk("async_rst_oe", {28'h0, init_b_oe}, 32'h0);
    chk("async_rst_gready", {28'h0, gready_o}, 32'h0);
    repeat (2) @(negedge clk_i);
    rst_b_i = 1'b1;
    for (int n = 0; n < 4; n++) begin timed[n] = 0; mstate[n] = 0; end
    m_to = 0; m_crc = 0; m_lost = 0;
    repeat (3) @(negedge clk_i);
    chk_status("post_reset_status");
    chk_err("post_reset_err");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glitc_config_ctrl.md
Name: glitc_config_ctrl

Overview:
- Per-GLITC configuration sequencer for the four GLITC FPGAs.
- Drives PROGRAM_B and INIT_B, and watches INIT_B and DONE.
- Produces the gready vector consumed by the GLITCBUS master. While a GLITC's gready bit is 0, GLITCBUS accesses to it are byte-wide SelectMAP config writes.
- Software controls it through a small Wishbone-style register slave in TISC space.

Parameters:
- PROG_CYCLES, 64: clk_i cycles PROGRAM_B is held low.
- INIT_HOLD_CYCLES, 64: clk_i cycles INIT_B is held low after PROGRAM_B is released.
- INIT_TIMEOUT, 65536: max cycles to wait for INIT_B to go high before error.

Ports:
- clk_i  in  1  system clock
- rst_b_i  in  1  asynchronous active-low reset
- cyc_i  in  1  bus cycle
- stb_i  in  1  bus strobe
- we_i  in  1  write enable
- adr_i  in  2  word address
- dat_i  in  32  write data
- dat_o  out  32  read data
- ack_o  out  1  single-cycle acknowledge
- PROGRAM_B  out  4  per-GLITC PROGRAM_B, active low
- init_b_oe  out  4  1 = drive INIT_B[n] low; 0 = release (external pull-up)
- INIT_B  in  4  sensed INIT_B pins
- DONE  in  4  sensed DONE pins
- gready_o  out  4  1 = GLITC n configured; feeds gready_i of the GLITCBUS master

Behaviour:
- Reset (async, rst_b_i low) sets:
  - all channels UNCONF; PROGRAM_B=4'hF; init_b_oe=0; gready_o=0
  - ack_o=0; dat_o=0; error flags cleared; counters cleared.
- INIT_B and DONE pass through 2-FF synchronisers (init_s, done_s) before any use.
- Bus access:
  - An access is accepted when cyc_i & stb_i & !ack_o.
  - ack_o pulses high exactly 1 cycle later, then returns low.
  - dat_o is registered together with ack_o.
  - A write takes effect on the accept edge.
- Register map:
  - adr 0 CONTROL (W): [3:0] start[n]; [7:4] abort[n]. Reads 0.
  - adr 1 STATUS (R): [4n+2:4n] state code of channel n (n=0..3); [19:16] gready_o; [23:20] done_s; [27:24] init_s.
  - adr 2 ERROR (R): [3:0] init-timeout; [7:4] CRC error (INIT_B low while LOADING); [11:8] DONE lost while READY.
  - adr 3: reads 0; writes ignored.
- Per-channel FSM (4 independent copies). Codes: UNCONF=0, PROG=1, INIT_HOLD=2, INIT_WAIT=3, LOADING=4, READY=5, ERROR=6.
  - UNCONF: outputs idle. start[n] -> PROG.
  - PROG: PROGRAM_B[n]=0 and init_b_oe[n]=1. Lasts exactly PROG_CYCLES cycles -> INIT_HOLD.
  - INIT_HOLD: PROGRAM_B[n]=1, init_b_oe[n]=1. Lasts exactly INIT_HOLD_CYCLES cycles -> INIT_WAIT.
  - INIT_WAIT: init_b_oe[n]=0. init_s[n]=1 -> LOADING. Counter reaching INIT_TIMEOUT with init_s[n] still 0 -> ERROR, set init-timeout[n].
  - LOADING: no timeout; software pushes bytes via GLITCBUS. done_s[n]=1 -> READY. Else init_s[n]=0 -> ERROR, set crc[n]. If both in the same cycle, DONE wins.
  - READY: gready_o[n]=1. done_s[n]=0 -> ERROR, set done-lost[n]; gready_o[n] drops the next cycle.
  - ERROR: outputs idle, gready_o[n]=0. Exits only via start or abort.
- Global start/abort rules:
  - start[n] from any state restarts at PROG: counter cleared, channel's error bits cleared.
  - abort[n] from any state -> UNCONF with error bits cleared.
  - start[n] and abort[n] written together: abort wins.
- All outputs are registered directly from state. gready_o[n]=1 iff state==READY.
- Counter is 17 bits per channel, reset on every state entry.
- Asynchronous reset mid-sequence immediately releases PROGRAM_B and INIT_B and clears gready_o.

Test Plan:
- Reset, then read adr 1 -> 0x0000_0000 with DONE=0, INIT_B=0; PROGRAM_B=F, init_b_oe=0, gready_o=0.
- Write adr0=0x1 with INIT_B pulled high after INIT_HOLD, DONE raised 100 cycles later:
  - PROGRAM_B[0] low for exactly 64 cycles, then init_b_oe[0] high for exactly 64 cycles.
  - State sequence 1,2,3,4,5; gready_o=0x1 three cycles after DONE rises (2 sync + 1 reg).
- Start channel 2 and hold INIT_B[2] low -> ERROR after 65536 cycles in INIT_WAIT; adr2 reads 0x004; gready_o[2]=0.
- Channel 1 in LOADING, pull INIT_B[1] low -> state 6, adr2 bit5 set. Then write 0x2 -> bit5 cleared, PROG restarts.
- Channel 3 READY, drop DONE[3] -> gready_o[3]=0 and adr2 bit11 set. Then write adr0=0x88 (start+abort) -> state 0, errors cleared.
- Assert rst_b_i low during PROG on channel 0 -> PROGRAM_B[0]=1 within the same cycle (async), all state codes 0.
